// File: rtl/integer_issue_queue.sv
// Integer issue queue: holds renamed integer ops until both operands are captured
// from dispatch or the CDB, then issues the lowest-index ready op to the ALU.
module integer_issue_queue #(
  parameter int DEPTH         = 8,
  parameter int TAG_WIDTH     = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int PAYLOAD_WIDTH = 48
) (
  input  logic                     clk,
  input  logic                     rst_aL,
  input  logic                     flush,
  input  logic                     iiq_dispatch_valid,
  output logic                     iiq_dispatch_ready,
  input  logic [PAYLOAD_WIDTH-1:0] iiq_dispatch_payload,
  input  logic [TAG_WIDTH-1:0]     iiq_dispatch_dst_tag,
  input  logic                     iiq_dispatch_src1_ready,
  input  logic                     iiq_dispatch_src2_ready,
  input  logic [TAG_WIDTH-1:0]     iiq_dispatch_src1_tag,
  input  logic [TAG_WIDTH-1:0]     iiq_dispatch_src2_tag,
  input  logic [DATA_WIDTH-1:0]    iiq_dispatch_src1_data,
  input  logic [DATA_WIDTH-1:0]    iiq_dispatch_src2_data,
  input  logic                     cdb_valid,
  input  logic [TAG_WIDTH-1:0]     cdb_tag,
  input  logic [DATA_WIDTH-1:0]    cdb_data,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [PAYLOAD_WIDTH-1:0] issue_payload,
  output logic [TAG_WIDTH-1:0]     issue_dst_tag,
  output logic [DATA_WIDTH-1:0]    issue_src1_data,
  output logic [DATA_WIDTH-1:0]    issue_src2_data,
  output logic [$clog2(DEPTH):0]   iiq_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0]         s1_rdy_q, s1_rdy_d;
  logic [DEPTH-1:0]         s2_rdy_q, s2_rdy_d;
  logic [PAYLOAD_WIDTH-1:0] payload_q [DEPTH];
  logic [PAYLOAD_WIDTH-1:0] payload_d [DEPTH];
  logic [TAG_WIDTH-1:0]     dst_tag_q [DEPTH];
  logic [TAG_WIDTH-1:0]     dst_tag_d [DEPTH];
  logic [TAG_WIDTH-1:0]     s1_tag_q  [DEPTH];
  logic [TAG_WIDTH-1:0]     s1_tag_d  [DEPTH];
  logic [TAG_WIDTH-1:0]     s2_tag_q  [DEPTH];
  logic [TAG_WIDTH-1:0]     s2_tag_d  [DEPTH];
  logic [DATA_WIDTH-1:0]    s1_data_q [DEPTH];
  logic [DATA_WIDTH-1:0]    s1_data_d [DEPTH];
  logic [DATA_WIDTH-1:0]    s2_data_q [DEPTH];
  logic [DATA_WIDTH-1:0]    s2_data_d [DEPTH];
  logic [CW-1:0]            count_q, count_d;

  logic [DEPTH-1:0] eligible;
  logic [IW-1:0]    issue_idx;
  logic [IW-1:0]    free_idx;
  logic             free_found;
  logic             disp_fire;
  logic             issue_fire;
  logic             cap1, cap2;

  assign eligible = valid_q & s1_rdy_q & s2_rdy_q;

  // Lowest-index eligible entry and lowest-index free slot, registered state only.
  always_comb begin
    issue_valid = 1'b0;
    issue_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!issue_valid && eligible[i]) begin
        issue_valid = 1'b1;
        issue_idx   = IW'(i);
      end
      if (!free_found && !valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  assign iiq_dispatch_ready = (count_q < CW'(DEPTH));
  assign disp_fire          = iiq_dispatch_valid && iiq_dispatch_ready && !flush;
  assign issue_fire         = issue_valid && issue_ready && !flush;
  assign cap1 = iiq_dispatch_src1_ready || (cdb_valid && (cdb_tag == iiq_dispatch_src1_tag));
  assign cap2 = iiq_dispatch_src2_ready || (cdb_valid && (cdb_tag == iiq_dispatch_src2_tag));

  always_comb begin
    valid_d  = valid_q;
    s1_rdy_d = s1_rdy_q;
    s2_rdy_d = s2_rdy_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      payload_d[i] = payload_q[i];
      dst_tag_d[i] = dst_tag_q[i];
      s1_tag_d[i]  = s1_tag_q[i];
      s2_tag_d[i]  = s2_tag_q[i];
      s1_data_d[i] = s1_data_q[i];
      s2_data_d[i] = s2_data_q[i];
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && cdb_valid) begin
        if (!s1_rdy_q[i] && (s1_tag_q[i] == cdb_tag)) begin
          s1_rdy_d[i]  = 1'b1;
          s1_data_d[i] = cdb_data;
        end
        if (!s2_rdy_q[i] && (s2_tag_q[i] == cdb_tag)) begin
          s2_rdy_d[i]  = 1'b1;
          s2_data_d[i] = cdb_data;
        end
      end
    end

    if (issue_fire) begin
      valid_d[issue_idx] = 1'b0;
    end

    // The free slot is invalid, so it never collides with wakeup or issue above.
    if (disp_fire) begin
      valid_d[free_idx]   = 1'b1;
      payload_d[free_idx] = iiq_dispatch_payload;
      dst_tag_d[free_idx] = iiq_dispatch_dst_tag;
      s1_tag_d[free_idx]  = iiq_dispatch_src1_tag;
      s2_tag_d[free_idx]  = iiq_dispatch_src2_tag;
      s1_rdy_d[free_idx]  = cap1;
      s2_rdy_d[free_idx]  = cap2;
      s1_data_d[free_idx] = iiq_dispatch_src1_ready ? iiq_dispatch_src1_data : cdb_data;
      s2_data_d[free_idx] = iiq_dispatch_src2_ready ? iiq_dispatch_src2_data : cdb_data;
    end

    case ({disp_fire, issue_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Entry contents are qualified by valid_q and need no reset.
  always_ff @(posedge clk) begin
    s1_rdy_q <= s1_rdy_d;
    s2_rdy_q <= s2_rdy_d;
    for (int i = 0; i < DEPTH; i++) begin
      payload_q[i] <= payload_d[i];
      dst_tag_q[i] <= dst_tag_d[i];
      s1_tag_q[i]  <= s1_tag_d[i];
      s2_tag_q[i]  <= s2_tag_d[i];
      s1_data_q[i] <= s1_data_d[i];
      s2_data_q[i] <= s2_data_d[i];
    end
  end

  assign issue_payload   = payload_q[issue_idx];
  assign issue_dst_tag   = dst_tag_q[issue_idx];
  assign issue_src1_data = s1_data_q[issue_idx];
  assign issue_src2_data = s2_data_q[issue_idx];
  assign iiq_count       = count_q;

endmodule

// File: tb/tb_integer_issue_queue.sv
// Bench for integer_issue_queue: directed vector table, hand-written corner
// sequences, then randomized traffic against a slot-array reference model.
module tb_integer_issue_queue;
  localparam int DEPTH = 8;
  localparam int TW    = 4;
  localparam int DW    = 32;
  localparam int PW    = 48;

  logic          clk = 1'b0;
  logic          rst_aL = 1'b0;
  logic          flush = 1'b0;
  logic          d_valid = 1'b0;
  logic          d_ready;
  logic [PW-1:0] d_payload = '0;
  logic [TW-1:0] d_dst = '0;
  logic          d_s1r = 1'b0, d_s2r = 1'b0;
  logic [TW-1:0] d_s1t = '0, d_s2t = '0;
  logic [DW-1:0] d_s1d = '0, d_s2d = '0;
  logic          cdb_valid = 1'b0;
  logic [TW-1:0] cdb_tag = '0;
  logic [DW-1:0] cdb_data = '0;
  logic          issue_valid;
  logic          issue_ready = 1'b0;
  logic [PW-1:0] issue_payload;
  logic [TW-1:0] issue_dst_tag;
  logic [DW-1:0] issue_src1_data, issue_src2_data;
  logic [3:0]    iiq_count;

  int n_pass = 0;
  int n_total = 0;

  integer_issue_queue #(.DEPTH(DEPTH), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .PAYLOAD_WIDTH(PW)) dut (
    .clk(clk), .rst_aL(rst_aL), .flush(flush),
    .iiq_dispatch_valid(d_valid), .iiq_dispatch_ready(d_ready),
    .iiq_dispatch_payload(d_payload), .iiq_dispatch_dst_tag(d_dst),
    .iiq_dispatch_src1_ready(d_s1r), .iiq_dispatch_src2_ready(d_s2r),
    .iiq_dispatch_src1_tag(d_s1t), .iiq_dispatch_src2_tag(d_s2t),
    .iiq_dispatch_src1_data(d_s1d), .iiq_dispatch_src2_data(d_s2d),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_payload(issue_payload), .issue_dst_tag(issue_dst_tag),
    .issue_src1_data(issue_src1_data), .issue_src2_data(issue_src2_data),
    .iiq_count(iiq_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [PW-1:0] pay_of(input logic [TW-1:0] t);
    return {t, 12'hA5C, 8'h3C, t, 16'hBEEF, t};
  endfunction

  task automatic drive(input bit dv, input logic [TW-1:0] dst,
                       input bit s1r, input logic [TW-1:0] s1t, input logic [DW-1:0] s1d,
                       input bit s2r, input logic [TW-1:0] s2t, input logic [DW-1:0] s2d,
                       input bit cv, input logic [TW-1:0] ct, input logic [DW-1:0] cd,
                       input bit ir, input bit fl);
    d_valid = dv; d_dst = dst; d_payload = pay_of(dst);
    d_s1r = s1r; d_s1t = s1t; d_s1d = s1d;
    d_s2r = s2r; d_s2t = s2t; d_s2d = s2d;
    cdb_valid = cv; cdb_tag = ct; cdb_data = cd;
    issue_ready = ir; flush = fl;
  endtask

  task automatic idle(input bit ir);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ir, 0);
  endtask

  task automatic chk_issue(input string nm, input logic [TW-1:0] dst,
                           input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    chk({nm, "_iv"}, 64'(issue_valid), 64'(1));
    chk({nm, "_dst"}, 64'(issue_dst_tag), 64'(dst));
    chk({nm, "_pay"}, 64'(issue_payload), 64'(pay_of(dst)));
    chk({nm, "_d1"}, 64'(issue_src1_data), 64'(e1));
    chk({nm, "_d2"}, 64'(issue_src2_data), 64'(e2));
  endtask

  typedef struct {
    bit dv; logic [TW-1:0] dst;
    bit s1r; logic [TW-1:0] s1t; logic [DW-1:0] s1d;
    bit s2r; logic [TW-1:0] s2t; logic [DW-1:0] s2d;
    bit cv; logic [TW-1:0] ct; logic [DW-1:0] cd;
    bit ir;
    bit e_iv; logic [3:0] e_cnt; logic [TW-1:0] e_dst; logic [DW-1:0] e_d1, e_d2;
  } vec_t;

  function automatic vec_t mk(input bit dv, input logic [TW-1:0] dst,
                              input bit s1r, input logic [TW-1:0] s1t, input logic [DW-1:0] s1d,
                              input bit s2r, input logic [TW-1:0] s2t, input logic [DW-1:0] s2d,
                              input bit cv, input logic [TW-1:0] ct, input logic [DW-1:0] cd,
                              input bit ir, input bit e_iv, input logic [3:0] e_cnt,
                              input logic [TW-1:0] e_dst, input logic [DW-1:0] e_d1,
                              input logic [DW-1:0] e_d2);
    vec_t v;
    v.dv = dv; v.dst = dst; v.s1r = s1r; v.s1t = s1t; v.s1d = s1d;
    v.s2r = s2r; v.s2t = s2t; v.s2d = s2d; v.cv = cv; v.ct = ct; v.cd = cd;
    v.ir = ir; v.e_iv = e_iv; v.e_cnt = e_cnt; v.e_dst = e_dst; v.e_d1 = e_d1; v.e_d2 = e_d2;
    return v;
  endfunction

  // Reference model: one record per slot, updated from the behavioural rules.
  typedef struct {
    bit v; logic [PW-1:0] pay; logic [TW-1:0] dst;
    bit r1, r2; logic [TW-1:0] t1, t2; logic [DW-1:0] d1, d2;
  } ment_t;
  ment_t m [DEPTH];

  initial begin
    vec_t vecs [14];
    vecs[0]  = mk(1, 3, 1, 0, 5, 1, 0, 7, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 5, 7);
    vecs[2]  = mk(1, 6, 0, 9, 0, 1, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'hABCD, 1, 0, 1, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 6, 32'hABCD, 2);
    vecs[6]  = mk(1, 7, 1, 0, 32'h22, 0, 4, 0, 1, 4, 32'h11, 1, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 7, 32'h22, 32'h11);
    vecs[8]  = mk(1, 8, 0, 2, 0, 1, 0, 0, 1, 5, 32'h55, 1, 0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h55, 1, 0, 1, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 32'h99, 1, 0, 1, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 32'h77, 0, 1, 1, 8, 32'h99, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 8, 32'h99, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Reset values
    #2;
    chk("rst_iv", 64'(issue_valid), 64'(0));
    chk("rst_cnt", 64'(iiq_count), 64'(0));
    chk("rst_dr", 64'(d_ready), 64'(1));
    @(negedge clk);
    rst_aL = 1'b1;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].dv, vecs[i].dst, vecs[i].s1r, vecs[i].s1t, vecs[i].s1d,
            vecs[i].s2r, vecs[i].s2t, vecs[i].s2d, vecs[i].cv, vecs[i].ct, vecs[i].cd,
            vecs[i].ir, 0);
      #1;
      chk($sformatf("vec%0d_iv", i), 64'(issue_valid), 64'(vecs[i].e_iv));
      chk($sformatf("vec%0d_cnt", i), 64'(iiq_count), 64'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_dr", i), 64'(d_ready), 64'(vecs[i].e_cnt < 4'd8));
      if (vecs[i].e_iv)
        chk_issue($sformatf("vec%0d", i), vecs[i].e_dst, vecs[i].e_d1, vecs[i].e_d2);
    end

    // Fill with entries waiting on tag 15, then wake them all together
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      drive(1, TW'(i), 0, 15, 0, 0, 15, 0, 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("fill%0d_cnt", i), 64'(iiq_count), 64'(i));
    end
    @(negedge clk);
    drive(1, 9, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("full_cnt", 64'(iiq_count), 64'(8));
    chk("full_dr", 64'(d_ready), 64'(0));
    chk("full_iv", 64'(issue_valid), 64'(0));
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 15, 32'hF00D, 0, 0);
    #1;
    chk("full_hold_cnt", 64'(iiq_count), 64'(8));
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      idle(1);
      #1;
      chk_issue($sformatf("order%0d", i), TW'(i), 32'hF00D, 32'hF00D);
      chk($sformatf("order%0d_cnt", i), 64'(iiq_count), 64'(8 - i));
    end
    @(negedge clk);
    idle(1);
    #1;
    chk("drain_cnt", 64'(iiq_count), 64'(0));
    chk("drain_iv", 64'(issue_valid), 64'(0));

    // Full queue, one eligible entry: issue and dispatch offered together
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      if (i == 0) drive(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      else        drive(1, TW'(i), 0, 15, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    drive(1, 12, 1, 0, 32'hC, 1, 0, 32'hD, 0, 0, 0, 1, 0);
    #1;
    chk("swap_cnt0", 64'(iiq_count), 64'(8));
    chk("swap_dr0", 64'(d_ready), 64'(0));
    chk_issue("swap_iss", 0, 0, 0);
    @(negedge clk);
    drive(1, 12, 1, 0, 32'hC, 1, 0, 32'hD, 0, 0, 0, 0, 0);
    #1;
    chk("swap_cnt1", 64'(iiq_count), 64'(7));
    chk("swap_dr1", 64'(d_ready), 64'(1));
    chk("swap_iv1", 64'(issue_valid), 64'(0));
    @(negedge clk);
    idle(0);
    #1;
    chk("swap_cnt2", 64'(iiq_count), 64'(8));
    chk_issue("swap_new", 12, 32'hC, 32'hD);

    // Flush beats a simultaneous dispatch and issue
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    idle(0);
    #1;
    chk("flush0_cnt", 64'(iiq_count), 64'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1, TW'(i), 1, 0, DW'(i), 1, 0, DW'(i + 1), 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    drive(1, 13, 1, 0, 1, 1, 0, 1, 0, 0, 0, 1, 1);
    #1;
    chk("flush_pre_cnt", 64'(iiq_count), 64'(5));
    chk_issue("flush_pre", 0, 0, 1);
    @(negedge clk);
    idle(1);
    #1;
    chk("flush_cnt", 64'(iiq_count), 64'(0));
    chk("flush_iv", 64'(issue_valid), 64'(0));
    chk("flush_dr", 64'(d_ready), 64'(1));

    // Asynchronous reset mid-operation
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1, TW'(i), 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    idle(0);
    #2;
    rst_aL = 1'b0;
    #1;
    chk("arst_cnt", 64'(iiq_count), 64'(0));
    chk("arst_iv", 64'(issue_valid), 64'(0));
    chk("arst_dr", 64'(d_ready), 64'(1));
    @(negedge clk);
    rst_aL = 1'b1;

    // Randomized traffic against the reference model
    for (int i = 0; i < DEPTH; i++) m[i].v = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int cnt, sel, fr;
      bit fire_d, fire_i;
      @(negedge clk);
      drive($urandom_range(0, 99) < 55, TW'($urandom_range(0, 15)),
            bit'($urandom_range(0, 1)), TW'($urandom_range(0, 3)), $urandom,
            bit'($urandom_range(0, 1)), TW'($urandom_range(0, 3)), $urandom,
            bit'($urandom_range(0, 1)), TW'($urandom_range(0, 3)), $urandom,
            $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 3);
      d_payload = {$urandom, $urandom};
      #1;
      cnt = 0; sel = -1; fr = -1;
      for (int k = 0; k < DEPTH; k++) begin
        if (m[k].v) cnt++;
        if (sel < 0 && m[k].v && m[k].r1 && m[k].r2) sel = k;
        if (fr < 0 && !m[k].v) fr = k;
      end
      chk("rnd_cnt", 64'(iiq_count), 64'(cnt));
      chk("rnd_dr", 64'(d_ready), 64'(cnt < DEPTH));
      chk("rnd_iv", 64'(issue_valid), 64'(sel >= 0));
      if (sel >= 0) begin
        chk("rnd_dst", 64'(issue_dst_tag), 64'(m[sel].dst));
        chk("rnd_pay", 64'(issue_payload), 64'(m[sel].pay));
        chk("rnd_d1", 64'(issue_src1_data), 64'(m[sel].d1));
        chk("rnd_d2", 64'(issue_src2_data), 64'(m[sel].d2));
      end
      fire_d = d_valid && (cnt < DEPTH);
      fire_i = (sel >= 0) && issue_ready;
      if (flush) begin
        for (int k = 0; k < DEPTH; k++) m[k].v = 0;
      end else begin
        for (int k = 0; k < DEPTH; k++) begin
          if (m[k].v && cdb_valid && !m[k].r1 && m[k].t1 == cdb_tag) begin
            m[k].r1 = 1; m[k].d1 = cdb_data;
          end
          if (m[k].v && cdb_valid && !m[k].r2 && m[k].t2 == cdb_tag) begin
            m[k].r2 = 1; m[k].d2 = cdb_data;
          end
        end
        if (fire_i) m[sel].v = 0;
        if (fire_d) begin
          m[fr].v = 1; m[fr].pay = d_payload; m[fr].dst = d_dst;
          m[fr].t1 = d_s1t; m[fr].t2 = d_s2t;
          m[fr].r1 = d_s1r || (cdb_valid && cdb_tag == d_s1t);
          m[fr].r2 = d_s2r || (cdb_valid && cdb_tag == d_s2t);
          m[fr].d1 = d_s1r ? d_s1d : cdb_data;
          m[fr].d2 = d_s2r ? d_s2d : cdb_data;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/integer_issue_queue.md
# integer_issue_queue

Integer issue queue sitting directly downstream of decode/rename/dispatch. It accepts renamed integer instructions on the `iiq_dispatch_*` handshake and holds them in a small buffer, capturing source operands from the common data bus (CDB) as producers complete. It issues one ready instruction per cycle to the integer ALU.

## Interface
- `DEPTH`, 8: entries (power of 2, ≥2)
- `TAG_WIDTH`, 4: ROB tag width (16-entry ROB)
- `DATA_WIDTH`, 32: operand width
- `PAYLOAD_WIDTH`, 48: opaque op/imm/control bits, carried unmodified

Ports:
- `clk` in 1: clock
- `rst_aL` in 1: asynchronous active-low reset
- `flush` in 1: synchronous squash of all entries
- `iiq_dispatch_valid` in 1: dispatch request
- `iiq_dispatch_ready` out 1: a free entry exists
- `iiq_dispatch_payload` in PAYLOAD_WIDTH: op/imm/control
- `iiq_dispatch_dst_tag` in TAG_WIDTH: destination ROB tag
- `iiq_dispatch_src1_ready`, `iiq_dispatch_src2_ready` in 1 each: operand value already known
- `iiq_dispatch_src1_tag`, `iiq_dispatch_src2_tag` in TAG_WIDTH each: producer tag when not ready
- `iiq_dispatch_src1_data`, `iiq_dispatch_src2_data` in DATA_WIDTH each: value when ready
- `cdb_valid` in 1: result broadcast
- `cdb_tag` in TAG_WIDTH: tag of the broadcast result
- `cdb_data` in DATA_WIDTH: broadcast value
- `issue_valid` out 1: an issuable entry is presented
- `issue_ready` in 1: ALU accepts
- `issue_payload` out PAYLOAD_WIDTH
- `issue_dst_tag` out TAG_WIDTH
- `issue_src1_data`, `issue_src2_data` out DATA_WIDTH each
- `iiq_count` out $clog2(DEPTH)+1: occupied entries

## Operation
- Entry state: `valid`, payload, dst_tag, and per source `rdy`/`tag`/`data`.
- Dispatch fires on `iiq_dispatch_valid && iiq_dispatch_ready`. It writes the lowest-index entry with `valid==0`, as registered at the start of the cycle.
- Dispatch-time CDB capture: if a source has `*_ready==0` and `cdb_valid` is high with `cdb_tag==*_tag` in the same cycle, that source is written as ready with `cdb_data`.
- Wakeup: every cycle, each valid entry with `rdy==0` and `tag==cdb_tag` under `cdb_valid` sets `rdy=1` and `data=cdb_data` in the next state. Both sources of one entry may wake together.
- Select: an entry is eligible when `valid && src1 rdy && src2 rdy`, using registered state only. The lowest-index eligible entry is presented. `issue_valid` = any eligible entry.
- Issue fires on `issue_valid && issue_ready`. The selected entry's `valid` clears at the clock edge.
- `iiq_dispatch_ready = (iiq_count < DEPTH)`, computed from registered state. A slot freed by an issue in the same cycle is not visible to dispatch until the next cycle.
- Dispatch and issue in the same cycle touch different entries by construction: the dispatch slot is invalid and the issue slot is valid. `iiq_count` stays unchanged in that case.
- `iiq_count` is an up/down counter: +1 on dispatch fire, −1 on issue fire.
- `flush` clears all `valid` bits and sets `iiq_count=0`. It overrides a dispatch or issue in the same cycle: nothing is written and the count does not change from either.
- Payload, tag and data outputs are don't-care when `issue_valid==0`. They are still driven deterministically from the entry at index 0.

## Timing
- Reset (async assert, sync release): all `valid=0`, `iiq_count=0`, `iiq_dispatch_ready=1`, `issue_valid=0`. Data fields are unreset.
- Dispatch-to-issue latency:
  - Both sources ready at dispatch: 1 cycle (dispatched at edge N, `issue_valid` in cycle N+1).
  - Waiting on a CDB broadcast in cycle M: issue in cycle M+1 at the earliest. There is no combinational CDB-to-issue path.
- Issue outputs are combinational from registered state. There is no combinational path from `issue_ready` to `iiq_dispatch_ready`.
- Full (`iiq_count==DEPTH`): `iiq_dispatch_ready=0`, and a held `iiq_dispatch_valid` is ignored.
- Empty: `issue_valid=0`, and `issue_ready` has no effect.
- A CDB tag matching no waiting source has no effect. Entries that are already ready ignore the CDB.
- `rst_aL` asserted mid-operation clears everything immediately, regardless of `clk`.

## Test plan
- Reset, then dispatch src1/src2 ready with data 0x5/0x7 and tag 3, holding `issue_ready=1` -> `issue_valid` the next cycle with data 5/7 and `issue_dst_tag=3`. `iiq_count` goes 1 then 0.
- Dispatch with src1 waiting on tag 9, then `cdb_valid`/`cdb_tag=9`/`cdb_data=0xABCD` two cycles later -> `issue_valid` rises one cycle after the broadcast with `issue_src1_data=0xABCD`.
- Dispatch with src2 waiting on tag 4 while the CDB broadcasts tag 4 with 0x11 in the same cycle -> issues the next cycle with `issue_src2_data=0x11`.
- Fill 8 entries, each waiting on tag 15, with `issue_ready=0` -> `iiq_dispatch_ready=0` and `iiq_count=8`, and a 9th request is not accepted. Broadcast tag 15 -> entries issue in index order 0..7, one per cycle with `issue_ready=1`.
- Full queue with one eligible entry, `issue_ready=1` and `iiq_dispatch_valid=1` -> in that cycle, issue fires and dispatch does not. The next cycle dispatch is accepted into the freed slot, and `iiq_count` goes 8, 7, 8.
- 5 entries occupied, `flush` asserted together with a dispatch and an issue handshake -> the next cycle `iiq_count=0`, `issue_valid=0`, and the flushed-cycle dispatch is absent.
